// File: rtl/spawn_placer.sv
// spawn_placer: picks a pseudo-random empty cell on a 2048 board and decides
// whether the new tile is a 2 or a 4. An xorshift32 generator advances every
// clock. On start the empty mask is latched and scanned linearly from a random
// index until an empty cell is found.
module spawn_placer #(
   parameter int          IDX_W       = 4,
   parameter int          VAL_W       = 4,
   parameter logic [31:0] SEED        = 32'h392a4953,
   parameter int          FOUR_THRESH = 26
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2**IDX_W-1:0]   empty_mask,
   input  logic                  seed_load,
   input  logic [31:0]           seed_in,
   output logic                  busy,
   output logic                  done,
   output logic                  full,
   output logic [IDX_W-1:0]      pos,
   output logic [VAL_W-1:0]      val
);

   localparam int CELLS = 2**IDX_W;

   typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

   state_t               state;
   logic [31:0]          x;
   logic [CELLS-1:0]     mask;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W:0]       k;
   logic                 four;
   logic                 four_now;

   function automatic logic [31:0] xs_next(input logic [31:0] v);
      logic [31:0] t;
      t = v ^ (v << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   // Tile-value decision on the current random value; 9 bits so 256 means "always".
   assign four_now = ({1'b0, x[31:24]} < 9'(FOUR_THRESH));

   // Free-running PRNG; a reseed wins over the advance, zero seeds fall back to SEED.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         x <= SEED;
      else if (seed_load)
         x <= (seed_in == 32'd0) ? SEED : seed_in;
      else
         x <= xs_next(x);
   end

   // Spawn FSM with registered status outputs; done is raised on entry to FIN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         mask  <= '0;
         idx   <= '0;
         k     <= '0;
         four  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         full  <= 1'b0;
         pos   <= '0;
         val   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mask <= empty_mask;
                  idx  <= x[IDX_W-1:0];
                  four <= four_now;
                  k    <= '0;
                  if (empty_mask == '0) begin
                     // no empty cell: report full straight away, pos/val untouched
                     state <= FIN;
                     done  <= 1'b1;
                     full  <= 1'b1;
                  end else begin
                     state <= SCAN;
                     busy  <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (mask[idx]) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  full  <= 1'b0;
                  pos   <= idx;
                  val   <= four ? VAL_W'(2) : VAL_W'(1);
               end else if (k == (IDX_W+1)'(CELLS)) begin
                  // unreachable with a nonzero mask; guards against a stuck scan
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  full  <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
                  k   <= k + 1'b1;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spawn_placer.sv
// Directed bench for spawn_placer: default instance plus FOUR_THRESH = 0 / 256
// instances sharing the same stimulus.
module tb_spawn_placer;

   localparam logic [31:0] SEED = 32'h392a4953;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] empty_mask = 16'h0;
   logic [31:0] seed_in = 32'h0;

   logic       busy0, done0, full0, busy1, done1, full1, busy2, done2, full2;
   logic [3:0] pos0, val0, pos1, val1, pos2, val2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit tmo     = 1'b0;

   // results of the last spawn
   logic [31:0] s_r;
   logic [3:0]  s_pos, s_val, s_v1, s_v2, e_pos, e_val;
   logic        s_full, s_bdone, s_dok, s_dafter;
   int          s_lat, s_bcnt, e_lat;

   spawn_placer u_dut (.clk(clk), .rst(rst), .start(start), .empty_mask(empty_mask),
      .seed_load(seed_load), .seed_in(seed_in), .busy(busy0), .done(done0),
      .full(full0), .pos(pos0), .val(val0));
   spawn_placer #(.FOUR_THRESH(0)) u_t0 (.clk(clk), .rst(rst), .start(start),
      .empty_mask(empty_mask), .seed_load(seed_load), .seed_in(seed_in), .busy(busy1),
      .done(done1), .full(full1), .pos(pos1), .val(val1));
   spawn_placer #(.FOUR_THRESH(256)) u_t256 (.clk(clk), .rst(rst), .start(start),
      .empty_mask(empty_mask), .seed_load(seed_load), .seed_in(seed_in), .busy(busy2),
      .done(done2), .full(full2), .pos(pos2), .val(val2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // reference xorshift32, tracking reset and reseed strobes
   logic [31:0] m_x;
   function automatic logic [31:0] xs(input logic [31:0] v);
      logic [31:0] t;
      t = v ^ (v << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction
   always @(posedge clk or negedge rst) begin
      if (!rst)           m_x <= SEED;
      else if (seed_load) m_x <= (seed_in == 32'd0) ? SEED : seed_in;
      else                m_x <= xs(m_x);
   end

   // Called at a negedge while the DUT is idle; returns at the negedge of the next idle cycle.
   task automatic do_spawn(input logic [15:0] m, input bit flip);
      logic [3:0] i;
      int k;
      s_r = m_x;
      start = 1'b1;
      empty_mask = m;
      e_pos = 4'd0;
      if (m == 16'h0) e_lat = 1;
      else begin
         i = s_r[3:0];
         k = 0;
         while (!m[i]) begin i = i + 4'd1; k++; end
         e_pos = i;
         e_lat = k + 2;
      end
      e_val = (s_r[31:24] < 8'd26) ? 4'd2 : 4'd1;
      @(negedge clk);
      start = 1'b0;
      if (flip) empty_mask = ~m;
      s_lat = 1;
      s_bcnt = 0;
      while (!done0 && s_lat < 40) begin
         if (busy0) s_bcnt++;
         @(negedge clk);
         s_lat++;
      end
      if (!done0) tmo = 1'b1;
      s_pos = pos0; s_val = val0; s_full = full0; s_bdone = busy0;
      s_v1 = val1; s_v2 = val2; s_dok = done1 && done2;
      @(negedge clk);
      s_dafter = done0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      n_tests++; if ({busy0, done0, full0} !== 3'b000) begin n_fail++;
         $display("FAIL reset_flags got %b exp 000", {busy0, done0, full0}); end
      n_tests++; if ({pos0, val0} !== 8'h00) begin n_fail++;
         $display("FAIL reset_posval got %h exp 00", {pos0, val0}); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_all_empty();
      do_spawn(16'hFFFF, 1'b0);
      n_tests++; if (s_lat !== 2) begin n_fail++;
         $display("FAIL all_empty_lat got %0d exp 2", s_lat); end
      n_tests++; if (s_pos !== s_r[3:0]) begin n_fail++;
         $display("FAIL all_empty_pos got %0d exp %0d", s_pos, s_r[3:0]); end
      n_tests++; if (s_full !== 1'b0 || s_val !== e_val) begin n_fail++;
         $display("FAIL all_empty_fullval got %b/%0d exp 0/%0d", s_full, s_val, e_val); end
      n_tests++; if (s_bcnt !== 1 || s_bdone !== 1'b0 || s_dafter !== 1'b0) begin n_fail++;
         $display("FAIL all_empty_busy got %0d/%b/%b exp 1/0/0", s_bcnt, s_bdone, s_dafter); end
   endtask

   task automatic test_single_cell();
      int bad_pos = 0, bad_lat = 0, bad_busy = 0, max_lat = 0;
      for (int n = 0; n < 50 && !tmo; n++) begin
         do_spawn(16'h0100, 1'b0);
         if (s_pos !== 4'd8 || s_val !== e_val) bad_pos++;
         if (s_lat !== 2 + ((8 - int'(s_r[3:0])) & 15)) bad_lat++;
         if (s_bcnt !== s_lat - 1) bad_busy++;
         if (s_lat > max_lat) max_lat = s_lat;
      end
      n_tests++; if (bad_pos !== 0) begin n_fail++;
         $display("FAIL single_pos bad=%0d exp 0 (last pos %0d)", bad_pos, s_pos); end
      n_tests++; if (bad_lat !== 0) begin n_fail++;
         $display("FAIL single_lat bad=%0d exp 0 (last %0d exp %0d)", bad_lat, s_lat, e_lat); end
      n_tests++; if (bad_busy !== 0) begin n_fail++;
         $display("FAIL single_busy bad=%0d exp 0", bad_busy); end
      n_tests++; if (max_lat > 17) begin n_fail++;
         $display("FAIL single_maxlat got %0d exp <=17", max_lat); end
   endtask

   task automatic test_full_board();
      logic [3:0] pp, pv;
      pp = pos0; pv = val0;
      do_spawn(16'h0000, 1'b0);
      n_tests++; if (s_lat !== 1 || s_full !== 1'b1) begin n_fail++;
         $display("FAIL full_done got lat %0d full %b exp 1/1", s_lat, s_full); end
      n_tests++; if (s_bcnt !== 0 || s_bdone !== 1'b0) begin n_fail++;
         $display("FAIL full_busy got %0d/%b exp 0/0", s_bcnt, s_bdone); end
      n_tests++; if (s_pos !== pp || s_val !== pv) begin n_fail++;
         $display("FAIL full_hold got %0d/%0d exp %0d/%0d", s_pos, s_val, pp, pv); end
      n_tests++; if (full0 !== 1'b1) begin n_fail++;
         $display("FAIL full_held got %b exp 1", full0); end
   endtask

   task automatic test_reset_mid_scan();
      int nd = 0;
      start = 1'b1; empty_mask = 16'h0001;
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      #1;
      n_tests++; if ({busy0, done0, full0, pos0, val0} !== 11'h0) begin n_fail++;
         $display("FAIL midreset_out got %h exp 0", {busy0, done0, full0, pos0, val0}); end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin @(negedge clk); if (done0) nd++; end
      n_tests++; if (nd !== 0) begin n_fail++;
         $display("FAIL midreset_done got %0d exp 0", nd); end
   endtask

   task automatic test_reseed();
      int bad = 0;
      seed_load = 1'b1; seed_in = 32'h1;
      @(negedge clk);
      seed_load = 1'b0;
      do_spawn(16'hFFFF, 1'b0);
      n_tests++; if (s_pos !== 4'd1 || s_val !== 4'd2 || s_lat !== 2) begin n_fail++;
         $display("FAIL reseed1 got %0d/%0d/%0d exp 1/2/2", s_pos, s_val, s_lat); end
      for (int n = 0; n < 8 && !tmo; n++) begin
         do_spawn(16'h0F0F, 1'b0);
         if (s_pos !== e_pos || s_val !== e_val || s_lat !== e_lat) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++;
         $display("FAIL reseed1_seq bad=%0d exp 0", bad); end
      seed_load = 1'b1; seed_in = 32'h0;
      @(negedge clk);
      seed_load = 1'b0;
      do_spawn(16'hFFFF, 1'b0);
      n_tests++; if (s_pos !== 4'd3 || s_val !== 4'd1 || s_lat !== 2) begin n_fail++;
         $display("FAIL reseed0 got %0d/%0d/%0d exp 3/1/2", s_pos, s_val, s_lat); end
   endtask

   task automatic test_start_while_busy();
      int nd = 0, first = 0;
      logic [3:0] i;
      int k;
      s_r = m_x;
      i = s_r[3:0]; k = 0;
      while (i != 4'd0) begin i = i + 4'd1; k++; end
      start = 1'b1; empty_mask = 16'h0001;
      @(negedge clk);            // SCAN: start still high, must be ignored
      @(negedge clk);
      start = 1'b0;
      for (int c = 2; c < 42; c++) begin
         if (done0) begin nd++; if (first == 0) first = c; end
         @(negedge clk);
      end
      n_tests++; if (nd !== 1) begin n_fail++;
         $display("FAIL busy_start_dones got %0d exp 1", nd); end
      n_tests++; if (first !== k + 2 || pos0 !== 4'd0) begin n_fail++;
         $display("FAIL busy_start_lat got %0d pos %0d exp %0d pos 0", first, pos0, k + 2); end
   endtask

   task automatic test_mask_flip();
      do_spawn(16'h0100, 1'b1);
      n_tests++; if (s_pos !== 4'd8 || s_lat !== e_lat) begin n_fail++;
         $display("FAIL flip_a got %0d/%0d exp 8/%0d", s_pos, s_lat, e_lat); end
      @(negedge clk);
      do_spawn(16'h8000, 1'b1);
      n_tests++; if (s_pos !== 4'd15 || s_lat !== e_lat) begin n_fail++;
         $display("FAIL flip_b got %0d/%0d exp 15/%0d", s_pos, s_lat, e_lat); end
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = cyc;
      for (int n = 0; n < 10; n++) do_spawn(16'hFFFF, 1'b0);
      n_tests++; if (cyc - c0 !== 30) begin n_fail++;
         $display("FAIL b2b_period got %0d exp 30", cyc - c0); end
   endtask

   task automatic test_tile_value();
      int bad = 0, bad0 = 0, bad256 = 0, n4 = 0;
      for (int n = 0; n < 10000 && !tmo; n++) begin
         do_spawn(16'hFFFF, 1'b0);
         if (s_pos !== e_pos || s_val !== e_val || s_lat !== 2) bad++;
         if (s_val === 4'd2) n4++;
         if (!s_dok || s_v1 !== 4'd1) bad0++;
         if (!s_dok || s_v2 !== 4'd2) bad256++;
      end
      n_tests++; if (bad !== 0) begin n_fail++;
         $display("FAIL tile_model bad=%0d exp 0", bad); end
      n_tests++; if (bad0 !== 0) begin n_fail++;
         $display("FAIL tile_thresh0 bad=%0d exp 0", bad0); end
      n_tests++; if (bad256 !== 0) begin n_fail++;
         $display("FAIL tile_thresh256 bad=%0d exp 0", bad256); end
      n_tests++; if (n4 < 800 || n4 > 1200) begin n_fail++;
         $display("FAIL tile_frac got %0d fours exp 800..1200", n4); end
   endtask

   initial begin
      test_reset();
      test_all_empty();
      test_single_cell();
      test_full_board();
      test_reset_mid_scan();
      test_reseed();
      test_start_while_busy();
      test_mask_flip();
      test_back_to_back();
      test_tile_value();
      n_tests++; if (tmo) begin n_fail++;
         $display("FAIL done_timeout got timeout exp none"); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spawn_placer.md
# spawn_placer

Parametrised tile-spawn unit for the 2048 board. On a `start` request it takes a snapshot of the empty-cell mask and picks one empty cell pseudo-randomly with an internal xorshift32 generator. It also decides whether the new tile is a 2 or a 4, then reports the result with a one-cycle `done` pulse. A full board is reported through a `full` flag. The unit sits between the move/merge logic and the board register file.

## Interface
- `IDX_W`, 4: cell index width; the board has `CELLS = 2**IDX_W` cells (4 gives 16 cells, a 4x4 board).
- `VAL_W`, 4: width of the tile exponent output.
- `SEED`, 32'h392a4953: PRNG reset value; must be nonzero.
- `FOUR_THRESH`, 26: 0..256; a tile is a 4 when `rand[31:24] < FOUR_THRESH` (26 gives about 10%).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: spawn request; sampled only in IDLE.
- `empty_mask` input CELLS: bit i = 1 means cell i is empty; sampled on the accepted `start` cycle only.
- `seed_load` input 1: synchronous reseed strobe; any state.
- `seed_in` input 32: reseed value; a value of 0 is replaced by `SEED`.
- `busy` output 1: high from the cycle after an accepted start until `done`.
- `done` output 1: one-cycle completion pulse.
- `full` output 1: valid with `done`, held afterwards; 1 means no empty cell existed.
- `pos` output IDX_W: chosen cell index; held until the next `done`.
- `val` output VAL_W: tile exponent, 1 for a 2 and 2 for a 4; held until the next `done`.

## Operation
- PRNG `x` is an xorshift32 that advances every clock: `x ^= x<<13; x ^= x>>17; x ^= x<<5`.
  - Reset sets `x = SEED`; the first advance occurs on the first clock edge after reset deasserts.
  - `seed_load` sets `x = seed_in` on the next edge, or `SEED` if `seed_in == 0`. It takes priority over the advance.
  - `rand` denotes the current value of `x`.
- FSM states are IDLE, SCAN and FIN.
  - IDLE, with `start` = 1: latch `mask = empty_mask`, `idx = rand[IDX_W-1:0]` and `four = (rand[31:24] < FOUR_THRESH)`.
    - If `mask == 0`, go to FIN with the full flag pending.
    - Otherwise go to SCAN with step count `k = 0`.
  - IDLE, with `start` = 0: stay.
  - SCAN: test `mask[idx]`.
    - If it is 1, record `idx` as the result and go to FIN.
    - Otherwise `idx <= idx + 1` (mod CELLS, wrapping from CELLS-1 to 0) and `k <= k + 1`.
    - A hit is guaranteed within CELLS steps because the mask is nonzero. As an internal safety net, if `k` reaches CELLS, go to FIN with `full` = 1.
  - FIN: drive `done` = 1 and update the outputs, then go to IDLE.
    - Normal result: `pos` = recorded idx, `val` = 2 if `four` else 1, `full` = 0.
    - Full board: `full` = 1; `pos` and `val` keep their previous values.
- `start` while `busy` or in FIN is ignored; it is not queued.
- The latched mask makes the result independent of `empty_mask` changes after acceptance.
- Reset values:
  - State IDLE.
  - `busy` = 0, `done` = 0, `full` = 0.
  - `pos` = 0, `val` = 0.
  - `x = SEED`.
- Reset asserted mid-scan aborts immediately to reset values; no `done` is produced.

## Timing
- `start` is accepted at edge T0.
- When a hit is found at scan step k (0..CELLS-1):
  - `busy` = 1 during cycles T0+1 .. T0+k+1.
  - `done` = 1 during cycle T0+k+2, with `pos`, `val` and `full` valid in that same cycle.
  - Worst-case latency is CELLS+1 cycles.
- With a full board, `done` = 1 and `full` = 1 during cycle T0+1, and `busy` stays 0.
- The earliest next accepted `start` is the cycle after `done`; back-to-back requests complete one every k+3 cycles.
- The `rand` used is the value of `x` in the cycle `start` is sampled. The bench models the PRNG from reset and the `seed_load` events.

## Test plan
- **All cells empty:** reset, then `start` with `empty_mask` = 16'hFFFF → `done` 2 cycles later, `pos = rand[3:0]` at the start cycle, `full` = 0.
- **Single empty cell:** `empty_mask` = 16'h0100, repeated over 50 starts → `pos` = 8 every time, `done` latency = 2 + ((8 - rand[3:0]) mod 16), never above 17.
- **Full board:** `empty_mask` = 16'h0000 → `done` and `full` = 1 one cycle after start, `busy` never high, `pos`/`val` unchanged.
- **Tile value rule:** `FOUR_THRESH` = 0 → `val` always 1; `FOUR_THRESH` = 256 → `val` always 2; default setting over 10k spawns → fraction of 4s in 0.08..0.12.
- **Reseed determinism:** `seed_load` with `seed_in` = 32'h1 → result sequence matches the bench model seeded with 1; `seed_in` = 0 → sequence matches `SEED`.
- **Robustness:** `start` pulsed during `busy` → ignored, exactly one `done`. Reset asserted mid-scan → outputs return to reset values at once, no `done`. Flip `empty_mask` after acceptance → result is unaffected.
